imm_encoder_32bit: RTL and testbench
====================================

# imm_encoder_32bit

Streaming immediate encoder for the RV32I datapath: accepts a 32-bit immediate, a format code and the non-immediate instruction bits ins[31:7], and returns ins[31:7] with the immediate scattered into its format-specific bit positions. It is the encode-side counterpart of the immediate extender: for every representable immediate, decoding the output yields the original value. It sits in the instruction-patch / self-modifying-code path and the bench golden-model path. It has a valid/ready input, a 2-entry output buffer, per-beat error flagging and a saturating error counter.

## Interface
- No parameters; all widths are fixed.
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- EXT_CNT  in  3  format: 000 I, 001 S, 010 SB, 011 U, 100 UJ, 101 I-unsigned, 110/111 illegal
- IN_IMM  in  32  immediate value to encode
- IN_BASE  in  25  ins[31:7] carrying rd/rs/funct bits; immediate positions in it are overwritten
- IN_VALID  in  1  input beat valid
- IN_READY  out  1  input beat accepted when IN_VALID && IN_READY
- OUT_DATA  out  25  encoded ins[31:7]
- OUT_ERR  out  1  beat's immediate not representable, or format illegal
- OUT_VALID  out  1  head of output buffer valid
- OUT_READY  in  1  consumer takes head when OUT_VALID && OUT_READY
- CLR_ERR  in  1  synchronous clear of ERR_CNT
- ERR_CNT  out  8  saturating count of accepted beats with OUT_ERR = 1

## Operation
- Bit placement (O = OUT_DATA, i = IN_IMM). Bits not listed come from IN_BASE.
  - I / I-unsigned: O[24:13] = i[11:0].
  - S: O[24:18] = i[11:5]; O[4:0] = i[4:0].
  - SB: O[24] = i[12]; O[23:18] = i[10:5]; O[4:1] = i[4:1]; O[0] = i[11].
  - U: O[24:5] = i[31:12].
  - UJ: O[24] = i[20]; O[23:18] = i[10:5]; O[17:14] = i[4:1]; O[13] = i[11]; O[12:5] = i[19:12].
  - Illegal formats: O = IN_BASE unchanged and the error flag is set.
- Range rules. A beat whose immediate breaks its rule is flagged as an error. Truncated bits are still encoded as listed.
  - I / S: i[31:11] must be all equal.
  - SB: i[31:12] must be all equal, and i[0] = 0.
  - U: i[11:0] must be 0.
  - UJ: i[31:20] must be all equal, and i[0] = 0.
  - I-unsigned: i[31:12] must be 0.
- Encoding is combinational on the input. The result is written into a 2-entry FIFO on acceptance.
- IN_READY = (FIFO count != 2), driven from registered count only. A simultaneous pop while full does not raise IN_READY in the same cycle.
- Push and pop in the same cycle: count is unchanged and order is preserved.
- ERR_CNT increments on each accepted beat with the error flag set, and saturates at 255.
- CLR_ERR has priority: when CLR_ERR is high in a cycle, ERR_CNT becomes 0, even if an error beat is accepted that cycle.

## Timing
- Latency: a beat accepted at edge N appears on OUT_DATA/OUT_ERR with OUT_VALID = 1 after edge N.
- Throughput: 1 beat per cycle when OUT_READY is held high.
- OUT_DATA, OUT_ERR and OUT_VALID are driven from the FIFO head registers. There is no combinational path from IN_* to OUT_*.
- OUT_DATA and OUT_ERR stay stable while OUT_VALID && !OUT_READY.
- Reset values: OUT_VALID 0, OUT_DATA 0, OUT_ERR 0, ERR_CNT 0, IN_READY 1 (once RST deasserts), FIFO count 0.
- Reset mid-operation: all buffered beats are discarded immediately. A beat presented during reset is not accepted.

## Configuration
- IMM_RANGE_CHECK_EN defined: range rules are enforced as above.
- IMM_RANGE_CHECK_EN undefined:
  - The range-check logic is removed.
  - OUT_ERR is set only for formats 110/111, and ERR_CNT counts only those.
  - Out-of-range immediates are silently truncated per the placement rules.

## Test plan
- Round trip: for each format 000–101, send 1,000 random representable immediates with IN_BASE = 0 and OUT_READY = 1. Pass: the extender output on OUT_DATA equals IN_IMM, OUT_ERR = 0, OUT_VALID exactly one cycle after acceptance.
- Field merge: EXT_CNT = 001, IN_IMM = 0xFFFFF800, IN_BASE = 0x0ABCDE0 -> OUT_DATA = 0x1000000 | (IN_BASE & 0x003FFE0), OUT_ERR = 0.
- Range errors (macro defined):
  - SB with IN_IMM = 0x00000003 -> OUT_ERR = 1, ERR_CNT = 1.
  - U with IN_IMM = 0x12345001 -> OUT_ERR = 1, O[24:5] = 0x12345.
  - Macro undefined: both of the above give OUT_ERR = 0.
- Backpressure: OUT_READY = 0, offer 3 beats -> IN_READY drops after 2 accepts. Raise OUT_READY -> beats emerge in order, 1 per cycle. The third beat is accepted the cycle after count leaves 2.
- Counter: 300 EXT_CNT = 111 beats -> ERR_CNT = 255. Assert CLR_ERR on the same cycle as an error beat -> ERR_CNT = 0 next cycle.
- Async reset with 2 beats buffered -> OUT_VALID = 0 and ERR_CNT = 0 immediately, without a clock edge. First beat after release has 1-cycle latency.

Source files
------------

// File: rtl/imm_encoder_32bit_if.sv
// Streaming bus for imm_encoder_32bit: input beat handshake, output buffer head and error counter.
// The slave modport is the encoder side; master is the producer/consumer side.
interface imm_encoder_32bit_if;
  logic [2:0]  EXT_CNT;
  logic [31:0] IN_IMM;
  logic [24:0] IN_BASE;
  logic        IN_VALID;
  logic        IN_READY;
  logic [24:0] OUT_DATA;
  logic        OUT_ERR;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        CLR_ERR;
  logic [7:0]  ERR_CNT;

  modport master (
    output EXT_CNT, IN_IMM, IN_BASE, IN_VALID, OUT_READY, CLR_ERR,
    input  IN_READY, OUT_DATA, OUT_ERR, OUT_VALID, ERR_CNT
  );

  modport slave (
    input  EXT_CNT, IN_IMM, IN_BASE, IN_VALID, OUT_READY, CLR_ERR,
    output IN_READY, OUT_DATA, OUT_ERR, OUT_VALID, ERR_CNT
  );
endinterface

// File: rtl/imm_encoder_32bit.sv
// RV32I immediate encoder: scatters IN_IMM into ins[31:7], buffered in a 2-entry FIFO.
// Define IMM_RANGE_CHECK_EN to flag immediates that do not fit their format.
module imm_encoder_32bit (
  input logic                 CLK,
  input logic                 RST,
  imm_encoder_32bit_if.slave  bus
);

  logic [24:0] enc_data;
  logic        enc_err;
  logic        range_ok;
  logic        beat_err;
  logic [31:0] imm;

  assign imm = bus.IN_IMM;

  always_comb begin
    enc_data = bus.IN_BASE;
    enc_err  = 1'b0;
    case (bus.EXT_CNT)
      3'b000, 3'b101: enc_data[24:13] = imm[11:0];
      3'b001: begin
        enc_data[24:18] = imm[11:5];
        enc_data[4:0]   = imm[4:0];
      end
      3'b010: begin
        enc_data[24]    = imm[12];
        enc_data[23:18] = imm[10:5];
        enc_data[4:1]   = imm[4:1];
        enc_data[0]     = imm[11];
      end
      3'b011: enc_data[24:5] = imm[31:12];
      3'b100: begin
        enc_data[24]    = imm[20];
        enc_data[23:18] = imm[10:5];
        enc_data[17:14] = imm[4:1];
        enc_data[13]    = imm[11];
        enc_data[12:5]  = imm[19:12];
      end
      default: enc_err = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Sign-extended formats need every bit above the top encoded bit to match it.
  always_comb begin
    range_ok = 1'b1;
    case (bus.EXT_CNT)
      3'b000, 3'b001: range_ok = (&imm[31:11]) | ~(|imm[31:11]);
      3'b010:         range_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
      3'b011:         range_ok = ~(|imm[11:0]);
      3'b100:         range_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
      3'b101:         range_ok = ~(|imm[31:12]);
      default:        range_ok = 1'b1;
    endcase
  end
`else
  assign range_ok = 1'b1;
`endif

  assign beat_err = enc_err | ~range_ok;

  // 2-entry FIFO, entries hold {err, data}
  logic [25:0] mem_q [2];
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [1:0]  count_q, count_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        push;
  logic        pop;

  // Ready comes only from registered state, so a pop while full cannot admit a beat that cycle.
  assign bus.IN_READY  = (count_q != 2'd2) & ~RST;
  assign bus.OUT_VALID = (count_q != 2'd0);
  assign bus.OUT_DATA  = mem_q[rd_ptr_q][24:0];
  assign bus.OUT_ERR   = mem_q[rd_ptr_q][25];
  assign bus.ERR_CNT   = err_cnt_q;

  assign push = bus.IN_VALID & bus.IN_READY;
  assign pop  = bus.OUT_VALID & bus.OUT_READY;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.CLR_ERR) begin
      err_cnt_d = 8'd0;
    end else if (push && beat_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      err_cnt_q <= 8'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {beat_err, enc_data};
      end
      wr_ptr_q  <= wr_ptr_q ^ push;
      rd_ptr_q  <= rd_ptr_q ^ pop;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_encoder_32bit.sv
// Scoreboard bench for imm_encoder_32bit: random round trips against a table-driven model
// plus directed merge, range, backpressure, counter and async-reset scenarios.
module tb_imm_encoder_32bit;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  imm_encoder_32bit_if bus ();

  imm_encoder_32bit dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit RangeEn = 1'b1;
`else
  localparam bit RangeEn = 1'b0;
`endif

  typedef struct {
    logic [24:0] data;
    logic        err;
    logic [2:0]  fmt;
    logic [31:0] imm;
    bit          rt;
    bit          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   src_map [6][25];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output bits O[ohi:olo] take immediate bits ending at ihi.
  task automatic map_field(input int f, input int ohi, input int olo, input int ihi);
    for (int k = 0; k <= ohi - olo; k++) src_map[f][olo + k] = ihi - (ohi - olo) + k;
  endtask

  function automatic logic [24:0] model_data(input logic [2:0] f, input logic [31:0] v,
                                             input logic [24:0] base);
    logic [24:0] o;
    o = base;
    if (f <= 3'd5) begin
      for (int j = 0; j < 25; j++) begin
        if (src_map[f][j] >= 0) o[j] = v[src_map[f][j]];
      end
    end
    return o;
  endfunction

  function automatic bit representable(input logic [2:0] f, input logic [31:0] v);
    longint s;
    s = longint'($signed(v));
    case (f)
      3'd0, 3'd1: return (s >= -2048) && (s <= 2047);
      3'd2:       return (s >= -4096) && (s <= 4095) && (v % 32'd2 == 0);
      3'd3:       return (v % 32'd4096) == 0;
      3'd4:       return (s >= -(64'sd1 << 20)) && (s < (64'sd1 << 20)) && (v % 32'd2 == 0);
      3'd5:       return v < 32'd4096;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic model_err(input logic [2:0] f, input logic [31:0] v);
    return (f > 3'd5) || (RangeEn && !representable(f, v));
  endfunction

  // Immediate extender: recovers the immediate from encoded ins[31:7].
  function automatic logic [31:0] decode(input logic [2:0] f, input logic [24:0] o);
    case (f)
      3'd0:    return {{20{o[24]}}, o[24:13]};
      3'd1:    return {{20{o[24]}}, o[24:18], o[4:0]};
      3'd2:    return {{19{o[24]}}, o[24], o[0], o[23:18], o[4:1], 1'b0};
      3'd3:    return {o[24:5], 12'b0};
      3'd4:    return {{11{o[24]}}, o[24], o[12:5], o[13], o[23:18], o[17:14], 1'b0};
      3'd5:    return {20'b0, o[24:13]};
      default: return 32'b0;
    endcase
  endfunction

  function automatic logic [31:0] gen(input logic [2:0] f);
    logic [31:0] r;
    r = $urandom;
    case (f)
      3'd0, 3'd1: return {{20{r[11]}}, r[11:0]};
      3'd2:       return {{19{r[12]}}, r[12:1], 1'b0};
      3'd3:       return {r[31:12], 12'b0};
      3'd4:       return {{11{r[20]}}, r[20:1], 1'b0};
      default:    return {20'b0, r[11:0]};
    endcase
  endfunction

  // Called just after a rising edge; returns just after the edge that accepts the beat.
  task automatic send(input logic [2:0] f, input logic [31:0] v, input logic [24:0] base,
                      input logic [24:0] exp_data, input logic exp_err,
                      input bit rt, input bit lat);
    bit   ok;
    exp_t e;
    bus.EXT_CNT  = f;
    bus.IN_IMM   = v;
    bus.IN_BASE  = base;
    bus.IN_VALID = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (bus.IN_READY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: IN_READY got 0, expected 1 within 50 cycles");
    end else begin
      e.data = exp_data; e.err = exp_err; e.fmt = f; e.imm = v;
      e.rt = rt; e.lat = lat; e.acc_cyc = cyc;
      sb_q.push_back(e);
    end
    @(posedge CLK);
    #1;
    bus.IN_VALID = 1'b0;
  endtask

  task automatic send_model(input logic [2:0] f, input logic [31:0] v, input logic [24:0] base,
                            input bit rt, input bit lat);
    send(f, v, base, model_data(f, v, base), model_err(f, v), rt, lat);
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (sb_q.size() == 0) break;
      @(negedge CLK);
    end
    check("drain_empty", sb_q.size(), 0);
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_clr();
    bus.CLR_ERR = 1'b1;
    @(posedge CLK);
    #1;
    bus.CLR_ERR = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (!RST && bus.OUT_VALID && bus.OUT_READY) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got OUT_VALID=1 data 0x%0h, expected no beat", bus.OUT_DATA);
      end else begin
        mon_e = sb_q.pop_front();
        check("out_data", bus.OUT_DATA, mon_e.data);
        check("out_err", bus.OUT_ERR, mon_e.err);
        if (mon_e.rt) check("round_trip", decode(mon_e.fmt, bus.OUT_DATA), mon_e.imm);
        if (mon_e.lat) check("latency", cyc - mon_e.acc_cyc, 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation got no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [24:0] base;
    for (int f = 0; f < 6; f++) for (int j = 0; j < 25; j++) src_map[f][j] = -1;
    map_field(0, 24, 13, 11);
    map_field(5, 24, 13, 11);
    map_field(1, 24, 18, 11); map_field(1, 4, 0, 4);
    map_field(2, 24, 24, 12); map_field(2, 23, 18, 10); map_field(2, 4, 1, 4);
    map_field(2, 0, 0, 11);
    map_field(3, 24, 5, 31);
    map_field(4, 24, 24, 20); map_field(4, 23, 18, 10); map_field(4, 17, 14, 4);
    map_field(4, 13, 13, 11); map_field(4, 12, 5, 19);

    bus.EXT_CNT = '0; bus.IN_IMM = '0; bus.IN_BASE = '0; bus.IN_VALID = 1'b0;
    bus.OUT_READY = 1'b0; bus.CLR_ERR = 1'b0;
    #12 RST = 1'b0;

    @(negedge CLK);
    check("rst_out_valid", bus.OUT_VALID, 0);
    check("rst_out_data", bus.OUT_DATA, 0);
    check("rst_out_err", bus.OUT_ERR, 0);
    check("rst_err_cnt", bus.ERR_CNT, 0);
    check("rst_in_ready", bus.IN_READY, 1);
    @(posedge CLK);
    #1;

    // Round trip of representable immediates, one beat per cycle
    bus.OUT_READY = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int n = 0; n < 1000; n++) send_model(3'(f), gen(3'(f)), 25'd0, 1'b1, 1'b1);
    end
    drain();
    check("rt_err_cnt", bus.ERR_CNT, 0);

    // Field merge with non-zero base
    send(3'd1, 32'hFFFFF800, 25'h0ABCDE0, 25'h1000000 | (25'h0ABCDE0 & 25'h003FFE0), 1'b0,
         1'b0, 1'b1);
    drain();

    // Out-of-range immediates
    pulse_clr();
    base = 25'($urandom);
    send(3'd2, 32'h00000003, base, (base & 25'h003FFE0) | 25'h2, RangeEn, 1'b0, 1'b0);
    drain();
    check("sb_err_cnt", bus.ERR_CNT, RangeEn ? 1 : 0);
    send(3'd3, 32'h12345001, base, {20'h12345, base[4:0]}, RangeEn, 1'b0, 1'b0);
    drain();
    check("u_err_cnt", bus.ERR_CNT, RangeEn ? 2 : 0);

    // Backpressure: two accepts fill the buffer, third waits for a pop
    bus.OUT_READY = 1'b0;
    send_model(3'd0, gen(3'd0), 25'($urandom), 1'b1, 1'b0);
    send_model(3'd4, gen(3'd4), 25'($urandom), 1'b1, 1'b0);
    @(negedge CLK);
    check("bp_full_ready", bus.IN_READY, 0);
    @(posedge CLK);
    #1;
    base = 25'($urandom);
    bus.EXT_CNT = 3'd3; bus.IN_IMM = 32'hABCDE000; bus.IN_BASE = base; bus.IN_VALID = 1'b1;
    bus.OUT_READY = 1'b1;
    @(negedge CLK);
    check("bp_pop_no_ready", bus.IN_READY, 0);
    check("bp_valid_a", bus.OUT_VALID, 1);
    @(negedge CLK);
    check("bp_ready_after", bus.IN_READY, 1);
    check("bp_valid_b", bus.OUT_VALID, 1);
    begin
      exp_t e;
      e.data = {20'hABCDE, base[4:0]}; e.err = 1'b0; e.fmt = 3'd3; e.imm = 32'hABCDE000;
      e.rt = 1'b1; e.lat = 1'b0; e.acc_cyc = cyc;
      sb_q.push_back(e);
    end
    @(posedge CLK);
    #1;
    bus.IN_VALID = 1'b0;
    @(negedge CLK);
    check("bp_valid_c", bus.OUT_VALID, 1);
    @(posedge CLK);
    #1;
    drain();

    // Saturating counter and clear priority
    pulse_clr();
    for (int n = 0; n < 300; n++) begin
      base = 25'($urandom);
      send(3'd7, $urandom, base, base, 1'b1, 1'b0, 1'b0);
    end
    drain();
    check("err_cnt_sat", bus.ERR_CNT, 255);
    bus.CLR_ERR = 1'b1;
    base = 25'($urandom);
    send(3'd6, $urandom, base, base, 1'b1, 1'b0, 1'b0);
    bus.CLR_ERR = 1'b0;
    check("clr_priority", bus.ERR_CNT, 0);
    drain();

    // Async reset with two beats buffered
    bus.OUT_READY = 1'b0;
    send(3'd6, 32'h1, 25'h1555555, 25'h1555555, 1'b1, 1'b0, 1'b0);
    send(3'd7, 32'h2, 25'h0AAAAAA, 25'h0AAAAAA, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    check("pre_rst_err_cnt", bus.ERR_CNT, 2);
    check("pre_rst_valid", bus.OUT_VALID, 1);
    #2 RST = 1'b1;
    #1;
    check("async_rst_valid", bus.OUT_VALID, 0);
    check("async_rst_err_cnt", bus.ERR_CNT, 0);
    check("async_rst_data", bus.OUT_DATA, 0);
    sb_q.delete();
    bus.EXT_CNT = 3'd0; bus.IN_IMM = 32'h5; bus.IN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    bus.IN_VALID = 1'b0;
    #3 RST = 1'b0;
    @(negedge CLK);
    check("no_accept_in_rst", bus.OUT_VALID, 0);
    @(posedge CLK);
    #1;
    bus.OUT_READY = 1'b1;
    send_model(3'd2, gen(3'd2), 25'($urandom), 1'b1, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
